// File: rtl/eeprom_pkg.sv
// Shared definitions for the AT25010 EEPROM read path.
// Holds the arbiter state encoding, bus widths and the AT25010 READ opcode
// (the opcode is also used by at25010_if).
package eeprom_pkg;

  localparam int unsigned EE_ADDR_W = 8;
  localparam int unsigned EE_DATA_W = 8;

  localparam logic [7:0] AT25010_OP_READ = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

endpackage

// File: rtl/eeprom_rd_arbiter_if.sv
// Link between the read arbiter and the at25010_if SPI read engine.
//   if_req_read   : one-cycle read strobe (arbiter -> engine)
//   if_addr       : byte address, held from strobe to completion
//   if_data       : read byte (engine -> arbiter)
//   if_data_valid : completion pulse (engine -> arbiter)
//   if_busy       : engine transaction in progress
// master = arbiter side, slave = engine side.
interface eeprom_rd_arbiter_if;
  import eeprom_pkg::*;

  logic                 if_req_read;
  logic [EE_ADDR_W-1:0] if_addr;
  logic [EE_DATA_W-1:0] if_data;
  logic                 if_data_valid;
  logic                 if_busy;

  modport master (
    output if_req_read,
    output if_addr,
    input  if_data,
    input  if_data_valid,
    input  if_busy
  );

  modport slave (
    input  if_req_read,
    input  if_addr,
    output if_data,
    output if_data_valid,
    output if_busy
  );

endinterface

// File: rtl/eeprom_rd_arbiter_rr_pick.sv
// Combinational rotate-priority encoder.
//   req      : pending request vector
//   last_gnt : index granted most recently
//   valid    : at least one request pending
//   idx      : first set request searching upward from last_gnt+1, wrapping
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W:0]   sum;

  always_comb begin
    // Rotate so bit 0 is the requester just above last_gnt; the doubled
    // vector makes the wrap-around free.
    rot   = N_REQ'({req, req} >> (32'(last_gnt) + 32'd1));
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        sum   = (IDX_W+1)'(last_gnt) + (IDX_W+1)'(k + 1);
        if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
        idx   = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/eeprom_rd_arbiter.sv
// Round-robin arbiter sharing one at25010_if read engine among N_REQ
// requesters. Each grant becomes a single-byte read; the result returns with
// a one-cycle ack to the winner. A watchdog forces an error completion
// (rd_err=1, data 0x00) if the engine never reports valid data.
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-requester level request, held until ack
//   req_addr  : packed byte addresses, requester i at [8i+7:8i]
//   ack       : one-hot completion pulse
//   rd_data   : read byte, valid with ack
//   rd_err    : completion was a timeout, valid with ack
//   ee        : engine-side bus (master modport)
module eeprom_rd_arbiter
  import eeprom_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [EE_ADDR_W*N_REQ-1:0]   req_addr,
  output logic [N_REQ-1:0]             ack,
  output logic [EE_DATA_W-1:0]         rd_data,
  output logic                         rd_err,
  eeprom_rd_arbiter_if.master          ee
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t           state;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     last_gnt;
  logic [CNT_W-1:0]     tmo_cnt;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [EE_ADDR_W-1:0] pick_addr;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  always_comb begin
    pick_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_addr = req_addr[EE_ADDR_W*i +: EE_ADDR_W];
    end
  end

  // The read strobe is registered, so the busy check for a strobe is made on
  // the edge that enters (or stays in) ISSUE; the cycle carrying the strobe
  // is the last ISSUE cycle and WAIT follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      gnt_idx        <= '0;
      last_gnt       <= IDX_W'(N_REQ - 1);
      tmo_cnt        <= '0;
      ack            <= '0;
      rd_data        <= '0;
      rd_err         <= 1'b0;
      ee.if_req_read <= 1'b0;
      ee.if_addr     <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_idx        <= pick_idx;
            ee.if_addr     <= pick_addr;
            ee.if_req_read <= !ee.if_busy;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ee.if_req_read) begin
            ee.if_req_read <= 1'b0;
            tmo_cnt        <= '0;
            state          <= ST_WAIT;
          end else if (!ee.if_busy) begin
            ee.if_req_read <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Data takes precedence over a coincident timeout.
          if (ee.if_data_valid) begin
            rd_data      <= ee.if_data;
            rd_err       <= 1'b0;
            ack[gnt_idx] <= 1'b1;
            state        <= ST_DONE;
          end else if (tmo_cnt == CNT_W'(TIMEOUT)) begin
            rd_data      <= '0;
            rd_err       <= 1'b1;
            ack[gnt_idx] <= 1'b1;
            state        <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          last_gnt <= gnt_idx;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_rd_arbiter.sv
module tb_eeprom_rd_arbiter;

  localparam int NR = 4;
  localparam int TMO = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [8*NR-1:0] req_addr = '0;
  logic [NR-1:0]   ack;
  logic [7:0]      rd_data;
  logic            rd_err;

  eeprom_rd_arbiter_if ee ();

  eeprom_rd_arbiter #(.N_REQ(NR), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .ack      (ack),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .ee       (ee.master)
  );

  always #5 clk = ~clk;

  // Behavioural read engine + EEPROM array, updated on the falling edge.
  logic [7:0] mem [256];
  logic       force_busy = 1'b0;
  logic       mute = 1'b0;
  int         eng_lat = 3;
  int         eng_cnt;
  logic       eng_busy, eng_valid;
  logic [7:0] eng_data, eng_addr;

  always @(negedge clk) begin
    if (rst) begin
      eng_busy  <= 1'b0;
      eng_valid <= 1'b0;
      eng_cnt   <= 0;
      eng_data  <= '0;
    end else begin
      eng_valid <= 1'b0;
      if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          eng_busy  <= 1'b0;
          eng_valid <= !mute;
          eng_data  <= mem[eng_addr];
        end
      end else if (ee.if_req_read) begin
        eng_busy <= 1'b1;
        eng_addr <= ee.if_addr;
        eng_cnt  <= eng_lat;
      end
    end
  end

  assign ee.if_data       = eng_data;
  assign ee.if_data_valid = eng_valid;
  assign ee.if_busy       = eng_busy | force_busy;

  int n_cmp = 0;
  int n_fail = 0;
  int n_strobe = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired waiting for DUT, required event never seen", name);
  endtask

  task automatic tick();
    @(negedge clk);
    if (ee.if_req_read) n_strobe++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    int c = 0;
    do begin
      tick();
      c++;
    end while (!ee.if_req_read && c < 200);
    if (!ee.if_req_read) bound_fail(name);
  endtask

  // Returns at the falling edge where ack is seen; cyc counts edges waited.
  task automatic wait_ack(input string name, output int idx, output logic [7:0] d,
                          output logic e, output int cyc);
    idx = -1; d = '0; e = 1'b0; cyc = 0;
    do begin
      tick();
      cyc++;
    end while (ack == '0 && cyc < 200);
    if (ack == '0) begin
      bound_fail(name);
    end else begin
      check({name, "_onehot"}, 32'($onehot(ack)), 32'd1);
      for (int i = 0; i < NR; i++) if (ack[i]) idx = i;
      d = rd_data;
      e = rd_err;
    end
  endtask

  function automatic int rr_model(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      int j;
      j = (last + k) % NR;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  typedef struct {
    logic [NR-1:0] mask;
    logic [31:0]   addrs;   // byte i = address of requester i
    int            n;
    logic [7:0]    order;   // 2 bits per expected grant, first grant in [1:0]
    logic [31:0]   data;    // byte g = data of grant g
  } vec_t;

  vec_t vecs[5];

  initial begin
    int idx, cyc, w, exp_idx, m_last;
    logic [7:0] d, exp_data, a;
    logic e, have_exp;
    int s0, acks;

    for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h5A;
    mem[8'h20] = 8'h3C;

    vecs[0] = '{mask: 4'b0001, addrs: 32'h00_00_00_10, n: 1, order: 8'b00_00_00_00, data: 32'h0000_00A5};
    vecs[1] = '{mask: 4'b1111, addrs: 32'h10_20_11_10, n: 4, order: 8'b11_10_01_00, data: 32'hA5_3C_5A_A5};
    vecs[2] = '{mask: 4'b1010, addrs: 32'h11_00_20_00, n: 2, order: 8'b00_00_11_01, data: 32'h0000_5A_3C};
    vecs[3] = '{mask: 4'b0100, addrs: 32'h00_11_00_00, n: 1, order: 8'b00_00_00_10, data: 32'h0000_005A};
    vecs[4] = '{mask: 4'b1100, addrs: 32'h20_10_00_00, n: 2, order: 8'b00_00_11_10, data: 32'h0000_3C_A5};

    do_reset();
    check("rst_ack", 32'(ack), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_err", 32'(rd_err), 0);
    check("rst_req_read", 32'(ee.if_req_read), 0);
    check("rst_if_addr", 32'(ee.if_addr), 0);

    // Table-driven: every vector starts from reset, so requester 0 leads.
    foreach (vecs[v]) begin
      do_reset();
      s0 = n_strobe;
      req_addr = vecs[v].addrs;
      req = vecs[v].mask;
      for (int g = 0; g < vecs[v].n; g++) begin
        logic [1:0] eo;
        logic [7:0] ed;
        eo = vecs[v].order[2*g +: 2];
        ed = vecs[v].data[8*g +: 8];
        wait_ack($sformatf("vec%0d_g%0d", v, g), idx, d, e, cyc);
        check($sformatf("vec%0d_g%0d_idx", v, g), 32'(idx), 32'(eo));
        check($sformatf("vec%0d_g%0d_data", v, g), 32'(d), 32'(ed));
        check($sformatf("vec%0d_g%0d_err", v, g), 32'(e), 0);
        if (idx >= 0) req[idx] = 1'b0;
      end
      acks = 0;
      repeat (8) begin tick(); if (ack != '0) acks++; end
      check($sformatf("vec%0d_extra_ack", v), 32'(acks), 0);
      check($sformatf("vec%0d_strobes", v), 32'(n_strobe - s0), 32'(vecs[v].n));
    end

    // Fairness: 1 and 2 re-request right after each ack.
    do_reset();
    req_addr = 32'h00_20_11_00;
    req = 4'b0110;
    for (int g = 0; g < 4; g++) begin
      wait_ack("fair", idx, d, e, cyc);
      check($sformatf("fair_g%0d", g), 32'(idx), (g % 2 == 0) ? 32'd1 : 32'd2);
    end
    req = '0;
    repeat (10) tick();

    // Timeout: engine never reports data.
    do_reset();
    mute = 1'b1;
    req_addr = 32'h00_00_11_10;
    req = 4'b0001;
    wait_strobe("tmo_strobe");
    wait_ack("tmo", idx, d, e, cyc);
    check("tmo_latency", 32'(cyc), 32'(TMO + 2));
    check("tmo_idx", 32'(idx), 0);
    check("tmo_err", 32'(e), 1);
    check("tmo_data", 32'(d), 0);
    req = 4'b0010;
    mute = 1'b0;
    wait_ack("tmo_next", idx, d, e, cyc);
    check("tmo_next_idx", 32'(idx), 1);
    check("tmo_next_data", 32'(d), 32'h5A);
    check("tmo_next_err", 32'(e), 0);
    req = '0;
    repeat (4) tick();

    // Busy hold: strobe waits for the engine to go idle.
    force_busy = 1'b1;
    req_addr = 32'h00_00_00_10;
    req = 4'b0001;
    s0 = n_strobe;
    repeat (10) tick();
    check("busy_no_strobe", 32'(n_strobe - s0), 0);
    force_busy = 1'b0;
    tick();
    check("busy_strobe_after_release", 32'(ee.if_req_read), 1);
    wait_ack("busy", idx, d, e, cyc);
    check("busy_idx", 32'(idx), 0);
    check("busy_data", 32'(d), 32'hA5);
    req = '0;
    repeat (4) tick();

    // Reset mid-WAIT: requester 2 aborted, requester 0 then wins over 1.
    eng_lat = 10;
    req_addr = 32'h00_20_11_10;
    req = 4'b0100;
    wait_strobe("rst_strobe");
    repeat (3) tick();
    rst = 1'b1;
    req = '0;
    tick();
    check("midrst_ack", 32'(ack), 0);
    check("midrst_rd_data", 32'(rd_data), 0);
    check("midrst_rd_err", 32'(rd_err), 0);
    check("midrst_req_read", 32'(ee.if_req_read), 0);
    check("midrst_if_addr", 32'(ee.if_addr), 0);
    rst = 1'b0;
    acks = 0;
    repeat (15) begin tick(); if (ack != '0) acks++; end
    check("midrst_no_ack", 32'(acks), 0);
    eng_lat = 3;
    req = 4'b0011;
    wait_ack("midrst_next", idx, d, e, cyc);
    check("midrst_next_idx", 32'(idx), 0);
    check("midrst_next_data", 32'(d), 32'hA5);
    req = '0;
    repeat (10) tick();

    // Randomised traffic against a round-robin scoreboard.
    do_reset();
    m_last = NR - 1;
    have_exp = 1'b0;
    exp_idx = 0;
    exp_data = '0;
    for (int c = 0; c < 3300; c++) begin
      tick();
      if (ee.if_req_read) begin
        w = rr_model(req, m_last);
        check("rnd_overlap", 32'(have_exp), 0);
        if (w < 0) begin
          bound_fail("rnd_spurious_strobe");
        end else begin
          a = req_addr[8*w +: 8];
          check("rnd_addr", 32'(ee.if_addr), 32'(a));
          exp_idx = w;
          exp_data = mem[a];
          m_last = w;
          have_exp = 1'b1;
        end
      end
      if (ack != '0) begin
        check("rnd_ack_expected", 32'(have_exp), 1);
        check("rnd_ack", 32'(ack), 32'(1) << exp_idx);
        check("rnd_data", 32'(rd_data), 32'(exp_data));
        check("rnd_err", 32'(rd_err), 0);
        have_exp = 1'b0;
        req = req & ~ack;
      end
      eng_lat = $urandom_range(1, 8);
      if (c < 3000) begin
        for (int i = 0; i < NR; i++) begin
          if (!req[i] && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
              0: a = 8'h10;
              1: a = 8'h11;
              2: a = 8'h20;
              default: a = 8'($urandom);
            endcase
            req_addr[8*i +: 8] = a;
            req[i] = 1'b1;
          end
        end
      end
    end
    check("rnd_drain_pending", 32'(have_exp), 0);
    check("rnd_drain_req", 32'(req), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
